// File: rtl/pipe_arith_pkg.sv
// Shared constants and stage payload for the pipelined arithmetic datapath.
// Optional macro PIPE_DIV_ZERO_FLAG_EN adds the per-stage divide-by-zero flag.
package pipe_arith_pkg;

    localparam int DW     = 8;
    localparam int VW     = 4;
    localparam int BPS    = 2;
    localparam int STAGES = DW / BPS;

    typedef struct packed {
        logic          valid;
        logic [VW:0]   rem;
        logic [DW-1:0] quo;
        logic [DW-1:0] dvd;
        logic [VW-1:0] div;
`ifdef PIPE_DIV_ZERO_FLAG_EN
        logic          zflag;
`endif
    } stage_t;

    // Bring the next dividend bit into the partial remainder.
    function automatic logic [VW:0] shift_in(input logic [VW:0] rem, input logic bit_in);
        return {rem[VW-1:0], bit_in};
    endfunction

endpackage

// File: rtl/div_stage.sv
// One restoring-division stage: resolves BPS quotient bits, then registers the payload.
// Divide-by-zero skips the subtractor so q collects ones and rem collects the dividend bits.
module div_stage
    import pipe_arith_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t i_stage,
    output stage_t o_stage
);

    stage_t      w_next;
    logic [VW:0] w_shift;

    // Resolve BPS quotient bits MSB first by trial subtraction.
    always_comb begin
        w_next  = i_stage;
        w_shift = '0;
        for (int b = 0; b < BPS; b++) begin
            w_shift    = shift_in(w_next.rem, w_next.dvd[DW-1]);
            w_next.dvd = {w_next.dvd[DW-2:0], 1'b0};
            if (i_stage.div == '0) begin
                w_next.rem = w_shift;
                w_next.quo = {w_next.quo[DW-2:0], 1'b1};
            end else if (w_shift >= {1'b0, i_stage.div}) begin
                w_next.rem = w_shift - {1'b0, i_stage.div};
                w_next.quo = {w_next.quo[DW-2:0], 1'b1};
            end else begin
                w_next.rem = w_shift;
                w_next.quo = {w_next.quo[DW-2:0], 1'b0};
            end
        end
    end

    // Stage register; reset clears the valid bit along with the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_stage <= '0;
        end else begin
            o_stage <= w_next;
        end
    end

endmodule

// File: rtl/pipelined_divider.sv
// Four-stage pipelined unsigned 8-by-4 divider with registered, bubble-gated outputs.
// Optional macro PIPE_DIV_ZERO_FLAG_EN exposes the div_zero output.
module pipelined_divider
    import pipe_arith_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] x,
    input  logic [VW-1:0] y,
    output logic          out_valid,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r
`ifdef PIPE_DIV_ZERO_FLAG_EN
    ,
    output logic          div_zero
`endif
);

    stage_t w_head;
    stage_t w_stage [STAGES];
    stage_t w_tail;
    logic   w_unused_tail;

    // Build the payload entering the first stage.
    always_comb begin
        w_head       = '0;
        w_head.valid = in_valid;
        w_head.dvd   = x;
        w_head.div   = y;
`ifdef PIPE_DIV_ZERO_FLAG_EN
        w_head.zflag = (y == '0);
`endif
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            div_stage u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_stage (w_head),
                .o_stage (w_stage[i])
            );
        end else begin : g_rest
            div_stage u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_stage (w_stage[i-1]),
                .o_stage (w_stage[i])
            );
        end
    end

    assign w_tail        = w_stage[STAGES-1];
    assign w_unused_tail = ^{w_tail.rem[VW], w_tail.dvd, w_tail.div};

    // Output register; bubbles read as all zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
`ifdef PIPE_DIV_ZERO_FLAG_EN
            div_zero  <= 1'b0;
`endif
        end else if (w_tail.valid) begin
            out_valid <= 1'b1;
            q         <= w_tail.quo;
            r         <= w_tail.rem[VW-1:0];
`ifdef PIPE_DIV_ZERO_FLAG_EN
            div_zero  <= w_tail.zflag;
`endif
        end else begin
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
`ifdef PIPE_DIV_ZERO_FLAG_EN
            div_zero  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_divider.sv
// Self-checking bench for pipelined_divider: directed spec cases plus a randomized run
// against a timestamp-queue reference model using plain integer division.
module tb_pipelined_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] x;
    logic [3:0] y;
    logic       out_valid;
    logic [7:0] q;
    logic [3:0] r;
`ifdef PIPE_DIV_ZERO_FLAG_EN
    logic       div_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;

    typedef struct {
        int t;
        int xv;
        int yv;
    } op_t;
    op_t pend[$];

    logic exp_valid;
    logic exp_z;
    int   exp_q, exp_r, exp_x, exp_y;

    always #5 clk = ~clk;

    pipelined_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .q         (q),
        .r         (r)
`ifdef PIPE_DIV_ZERO_FLAG_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    // Drive one cycle, advance the reference model to the new edge, settle outputs.
    task automatic tick(input logic rst_i, input logic v, input int xv, input int yv);
        op_t o;
        @(negedge clk);
        rst_n    = rst_i;
        in_valid = v;
        x        = xv[7:0];
        y        = yv[3:0];
        @(posedge clk);
        edge_no++;
        exp_valid = 1'b0;
        exp_z     = 1'b0;
        exp_q     = 0;
        exp_r     = 0;
        if (!rst_i) begin
            pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].t == edge_no - 4) begin
                o         = pend.pop_front();
                exp_valid = 1'b1;
                exp_x     = o.xv;
                exp_y     = o.yv;
                if (o.yv == 0) begin
                    exp_q = 255;
                    exp_r = o.xv % 16;
                    exp_z = 1'b1;
                end else begin
                    exp_q = o.xv / o.yv;
                    exp_r = o.xv % o.yv;
                end
            end
            if (v) pend.push_back('{edge_no, xv, yv});
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 200, 7);
        tick(1'b0, 1'b1, 13, 3);
        n_cmp++;
        if ({out_valid, q, r} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset: got v=%0b q=%0d r=%0d want all 0", out_valid, q, r);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 1'b1, 200, 7);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (out_valid !== (k == 3)) begin
                n_bad++;
                $display("FAIL single_latency k=%0d: got v=%0b want %0b", k, out_valid, (k == 3));
            end
        end
        n_cmp++;
        if ({out_valid, q, r} !== {1'b1, 8'd28, 4'd4}) begin
            n_bad++;
            $display("FAIL single: got v=%0b q=%0d r=%0d want v=1 q=28 r=4", out_valid, q, r);
        end
`ifdef PIPE_DIV_ZERO_FLAG_EN
        n_cmp++;
        if (div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL single_dz: got %0b want 0", div_zero);
        end
`endif
        tick(1'b1, 1'b0, 0, 0);
        n_cmp++;
        if ({out_valid, q, r} !== 13'd0) begin
            n_bad++;
            $display("FAIL single_gate: got v=%0b q=%0d r=%0d want all 0", out_valid, q, r);
        end
    endtask

    task automatic test_edges();
        int tx[6] = '{255, 15, 5, 0, 100, 0};
        int ty[6] = '{1, 15, 9, 3, 0, 0};
        int tq[6] = '{255, 1, 0, 0, 255, 255};
        int tr[6] = '{0, 0, 5, 0, 4, 0};
        for (int k = 0; k < 10; k++) begin
            if (k < 6) tick(1'b1, 1'b1, tx[k], ty[k]);
            else       tick(1'b1, 1'b0, 0, 0);
            if (k >= 4) begin
                n_cmp++;
                if ({out_valid, q, r} !== {1'b1, tq[k-4][7:0], tr[k-4][3:0]}) begin
                    n_bad++;
                    $display("FAIL edge %0d/%0d: got v=%0b q=%0d r=%0d want v=1 q=%0d r=%0d",
                             tx[k-4], ty[k-4], out_valid, q, r, tq[k-4], tr[k-4]);
                end
`ifdef PIPE_DIV_ZERO_FLAG_EN
                n_cmp++;
                if (div_zero !== (ty[k-4] == 0)) begin
                    n_bad++;
                    $display("FAIL edge_dz %0d/%0d: got %0b want %0b",
                             tx[k-4], ty[k-4], div_zero, (ty[k-4] == 0));
                end
`endif
            end
        end
    endtask

    task automatic test_back_to_back();
        int sx[8] = '{6, 40, 16, 27, 48, 35, 18, 24};
        int sy[8] = '{2, 5, 8, 3, 8, 5, 9, 4};
        int sq[8] = '{3, 8, 2, 9, 6, 7, 2, 6};
        logic tog[3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 13; k++) begin
            if (k < 8) tick(1'b1, 1'b1, sx[k], sy[k]);
            else       tick(1'b1, 1'b0, 0, 0);
            if (k >= 4 && k < 12) begin
                n_cmp++;
                if ({out_valid, q, r} !== {1'b1, sq[k-4][7:0], 4'd0}) begin
                    n_bad++;
                    $display("FAIL stream %0d: got v=%0b q=%0d r=%0d want v=1 q=%0d r=0",
                             k - 4, out_valid, q, r, sq[k-4]);
                end
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_end: got v=%0b want 0", out_valid);
        end
        for (int k = 0; k < 7; k++) begin
            if (k < 3) tick(1'b1, tog[k], 30 + k, 7);
            else       tick(1'b1, 1'b0, 0, 0);
            if (k >= 4) begin
                n_cmp++;
                if ({out_valid, q, r} !== {exp_valid, exp_q[7:0], exp_r[3:0]} || out_valid !== tog[k-4]) begin
                    n_bad++;
                    $display("FAIL toggle %0d: got v=%0b q=%0d r=%0d want v=%0b q=%0d r=%0d",
                             k - 4, out_valid, q, r, tog[k-4], exp_q, exp_r);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 1'b1, 99, 4);
        tick(1'b1, 1'b1, 88, 5);
        tick(1'b1, 1'b1, 77, 3);
        tick(1'b0, 1'b1, 66, 2);
        n_cmp++;
        if ({out_valid, q, r} !== 13'd0) begin
            n_bad++;
            $display("FAIL midreset: got v=%0b q=%0d r=%0d want all 0", out_valid, q, r);
        end
        tick(1'b1, 1'b1, 77, 6);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 0, 0);
            n_cmp++;
            if ({out_valid, q, r} !== ((k == 3) ? {1'b1, 8'd12, 4'd5} : 13'd0)) begin
                n_bad++;
                $display("FAIL post_reset k=%0d: got v=%0b q=%0d r=%0d want v=%0b q=%0d r=%0d",
                         k, out_valid, q, r, (k == 3), (k == 3) ? 12 : 0, (k == 3) ? 5 : 0);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1004; k++) begin
            if (k < 1000) tick(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                               int'($urandom_range(1, 15)));
            else          tick(1'b1, 1'b0, 0, 0);
            n_cmp++;
            if ({out_valid, q, r} !== {exp_valid, exp_q[7:0], exp_r[3:0]}) begin
                n_bad++;
                $display("FAIL random k=%0d: got v=%0b q=%0d r=%0d want v=%0b q=%0d r=%0d",
                         k, out_valid, q, r, exp_valid, exp_q, exp_r);
            end
`ifdef PIPE_DIV_ZERO_FLAG_EN
            n_cmp++;
            if (div_zero !== exp_z) begin
                n_bad++;
                $display("FAIL random_dz k=%0d: got %0b want %0b", k, div_zero, exp_z);
            end
`endif
            if (out_valid === 1'b1 && exp_valid) begin
                n_cmp++;
                if (exp_x != int'(q) * exp_y + int'(r) || int'(r) >= exp_y) begin
                    n_bad++;
                    $display("FAIL invariant %0d/%0d: got q=%0d r=%0d", exp_x, exp_y, q, r);
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = 8'd0;
        y        = 4'd0;
        test_reset();
        test_single();
        test_edges();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
